truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively drives every input combination into an N_IN-input, single-output combinational block (a 4-input function f(a,b,c,d) by default).
- Samples the block's output for each combination and assembles the measured truth table.
- Compares the measured table against an expected table and reports pass/fail, the mismatch count and the first failing index.
- Sits between a lab-board/top-level start control and the combinational unit under sweep, replacing hand-written stimulus sequences.

Parameters:
N_IN, 4, number of inputs of the swept combinational block; table depth is 2**N_IN.
SETTLE, 1, idle cycles between driving a vector and sampling dut_out (0 allowed).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a sweep; sampled only in IDLE.
expected  input  2**N_IN  expected truth table; bit i = expected output for input value i; captured on accepted start.
dut_in  output  N_IN  drive to swept block; dut_in[N_IN-1]=a … dut_in[0]=d.
dut_out  input  1  output of swept block.
table_out  output  2**N_IN  measured truth table; bit i = dut_out sampled while dut_in==i.
busy  output  1  high from the cycle after accepted start until FINISH exits.
done  output  1  level; high after a sweep completes, cleared by next accepted start.
pass  output  1  valid when done; 1 iff mismatch_cnt==0.
mismatch_cnt  output  N_IN+1  number of indices where table_out differs from expected.
first_fail  output  N_IN  lowest mismatching index; valid when fail_valid.
fail_valid  output  1  at least one mismatch recorded this sweep.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; dut_in, table_out, mismatch_cnt, first_fail = 0; busy, done, pass, fail_valid = 0; internal expected copy and counters = 0.
- FSM states: IDLE, WAIT, SAMPLE, FINISH.
- IDLE, start=1:
  - capture expected into exp_reg; clear table_out, mismatch_cnt, first_fail, fail_valid, done, pass.
  - set idx=0, dut_in=0, wait_cnt=SETTLE.
  - go to WAIT if SETTLE>0, else SAMPLE.
- WAIT: decrement wait_cnt each cycle; when wait_cnt==1, go to SAMPLE. Exactly SETTLE cycles are spent in WAIT.
- SAMPLE (one cycle):
  - table_out[idx] <= dut_out.
  - If dut_out != exp_reg[idx]: mismatch_cnt++. If fail_valid==0, also set first_fail=idx and fail_valid=1.
  - If idx==2**N_IN-1, go to FINISH.
  - Otherwise idx++, dut_in=idx+1, reload wait_cnt, go to WAIT (or SAMPLE if SETTLE==0).
- FINISH (one cycle): done<=1, pass<=(mismatch_cnt==0), go to IDLE. The mismatch count is already final at this point.
- busy = state != IDLE (registered state decode).
- Latency: one vector every SETTLE+1 cycles. done rises 2**N_IN*(SETTLE+1)+1 clock edges after the edge that accepted start (33 for defaults).
- start while busy: ignored, no effect on the sweep.
- start while done=1 in IDLE: accepted; done, pass and status clear on the next edge.
- dut_in holds its last value (2**N_IN-1) after completion until the next start or reset.
- expected changes during a sweep are ignored because exp_reg is used.
- Reset mid-sweep: immediate return to reset values; no partial done.
- mismatch_cnt never wraps; N_IN+1 bits holds the maximum 2**N_IN.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, WAIT=2'd1, SAMPLE=2'd2, FINISH=2'd3) and the default N_IN and SETTLE values.
- One natural sub-module, sweep_result_tracker: holds table_out, mismatch_cnt, first_fail and fail_valid, and updates them on a sample strobe. The FSM, index and settle counter stay in the top module.

Test Plan:
- Bench models dut_out as a^b^c^d; expected=16'h6996, SETTLE=1, start pulse → dut_in steps 0..15, each held 2 cycles; done=1 at edge 33; pass=1; mismatch_cnt=0; fail_valid=0; table_out=16'h6996.
- Same bench model, expected=16'h6997 → table_out=16'h6996, mismatch_cnt=1, first_fail=0, fail_valid=1, pass=0.
- Same bench model, expected=16'h0000 → mismatch_cnt=8, first_fail=1, pass=0.
- start re-asserted at cycles 5 and 20 of a sweep → sweep unaffected; done still at edge 33; results as in the first scenario.
- rst_n low while dut_in=7 → all outputs 0 immediately; a fresh start afterwards yields a clean 16'h6996 table and pass=1.
- SETTLE=0 build, bench models dut_out as a&b|c&d, expected=16'hF888 → done at edge 17, pass=1. A second start while done=1 → done=0 next cycle; busy=1.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg
//   Shared definitions for the truth-table sweeper: the sequencer state
//   encoding and the default build parameters.
package truth_table_sweeper_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam int DEF_N_IN   = 4;
   localparam int DEF_SETTLE = 1;

endpackage

// File: rtl/truth_table_sweeper_result_tracker.sv
// sweep_result_tracker
//   Accumulates the measured truth table and the mismatch statistics of one
//   sweep. Cleared when a sweep is accepted, updated once per sample strobe.
//
//   clk, rst_n     clock / asynchronous active-low reset
//   clear          start of a new sweep: zero all results
//   sample         strobe: record sample_bit at index idx
//   idx            input combination currently being sampled
//   sample_bit     sampled output of the swept block
//   exp_bit        expected output for idx
//   table_out      measured truth table (bit i = sample for input i)
//   mismatch_cnt   number of mismatching indices, saturation never needed
//   first_fail     lowest mismatching index, valid when fail_valid
//   fail_valid     at least one mismatch this sweep
module sweep_result_tracker #(
   parameter int N_IN = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 sample,
   input  logic [N_IN-1:0]      idx,
   input  logic                 sample_bit,
   input  logic                 exp_bit,
   output logic [2**N_IN-1:0]   table_out,
   output logic [N_IN:0]        mismatch_cnt,
   output logic [N_IN-1:0]      first_fail,
   output logic                 fail_valid
);

   localparam logic [N_IN:0] CNT_ONE = 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         table_out    <= '0;
         mismatch_cnt <= '0;
         first_fail   <= '0;
         fail_valid   <= 1'b0;
      end else if (clear) begin
         table_out    <= '0;
         mismatch_cnt <= '0;
         first_fail   <= '0;
         fail_valid   <= 1'b0;
      end else if (sample) begin
         table_out[idx] <= sample_bit;
         if (sample_bit != exp_bit) begin
            mismatch_cnt <= mismatch_cnt + CNT_ONE;
            // indices are swept in ascending order, so the first hit is the lowest
            if (!fail_valid) begin
               first_fail <= idx;
               fail_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Walks every input combination of an N_IN-input combinational block,
//   samples its output after SETTLE idle cycles per vector, builds the
//   measured truth table and compares it against an expected table.
//
//   clk, rst_n     clock / asynchronous active-low reset
//   start          begin a sweep (only honoured in IDLE)
//   expected       expected truth table, captured when a sweep starts
//   dut_in         vector driven to the swept block (MSB = a ... LSB = d)
//   dut_out        output of the swept block
//   table_out      measured truth table
//   busy           sweep in progress
//   done           sweep finished (level, cleared by next start)
//   pass           no mismatches, valid with done
//   mismatch_cnt   number of mismatching indices
//   first_fail     lowest mismatching index, valid with fail_valid
//   fail_valid     at least one mismatch this sweep
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int N_IN   = DEF_N_IN,
   parameter int SETTLE = DEF_SETTLE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   output logic [N_IN-1:0]      dut_in,
   input  logic                 dut_out,
   output logic [2**N_IN-1:0]   table_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        mismatch_cnt,
   output logic [N_IN-1:0]      first_fail,
   output logic                 fail_valid
);

   localparam int              WCW      = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [WCW-1:0]  WC_LOAD  = WCW'(SETTLE);
   localparam logic [WCW-1:0]  WC_ONE   = 1;
   localparam logic [N_IN-1:0] IDX_ONE  = 1;
   localparam logic [N_IN-1:0] IDX_LAST = '1;

   state_t                state, state_nxt;
   logic [2**N_IN-1:0]    exp_reg;
   logic [N_IN-1:0]       idx;
   logic [WCW-1:0]        wait_cnt;
   logic                  accept;
   logic                  sample_stb;
   logic                  last_idx;

   assign last_idx = (idx == IDX_LAST);
   // the driven vector is always the index being swept
   assign dut_in   = idx;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (start) state_nxt = (SETTLE > 0) ? WAIT : SAMPLE;
         WAIT:   if (wait_cnt == WC_ONE) state_nxt = SAMPLE;
         SAMPLE: begin
            if (last_idx)         state_nxt = FINISH;
            else if (SETTLE > 0)  state_nxt = WAIT;
            else                  state_nxt = SAMPLE;
         end
         FINISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // output / strobe decode
   always_comb begin
      busy       = (state != IDLE);
      accept     = (state == IDLE) && start;
      sample_stb = (state == SAMPLE);
   end

   // sweep datapath: captured table, index, settle counter, final status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_reg  <= '0;
         idx      <= '0;
         wait_cnt <= '0;
         done     <= 1'b0;
         pass     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  exp_reg  <= expected;
                  idx      <= '0;
                  wait_cnt <= WC_LOAD;
                  done     <= 1'b0;
                  pass     <= 1'b0;
               end
            end
            WAIT: wait_cnt <= wait_cnt - WC_ONE;
            SAMPLE: begin
               if (!last_idx) begin
                  idx      <= idx + IDX_ONE;
                  wait_cnt <= WC_LOAD;
               end
            end
            FINISH: begin
               done <= 1'b1;
               pass <= (mismatch_cnt == '0);
            end
            default: ;
         endcase
      end
   end

   sweep_result_tracker #(
      .N_IN (N_IN)
   ) u_tracker (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (accept),
      .sample       (sample_stb),
      .idx          (idx),
      .sample_bit   (dut_out),
      .exp_bit      (exp_reg[idx]),
      .table_out    (table_out),
      .mismatch_cnt (mismatch_cnt),
      .first_fail   (first_fail),
      .fail_valid   (fail_valid)
   );

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // instance A: default build (SETTLE=1), instance B: SETTLE=0
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [15:0] exp_a = '0, exp_b = '0;
   logic [15:0] func_a = '0, func_b = '0;
   logic [3:0]  dut_in_a, dut_in_b;
   logic        dut_out_a, dut_out_b;
   logic [15:0] table_a, table_b;
   logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
   logic [4:0]  mism_a, mism_b;
   logic [3:0]  ff_a, ff_b;
   logic        fv_a, fv_b;

   // swept block: arbitrary 4-input function given as a lookup table
   assign dut_out_a = func_a[dut_in_a];
   assign dut_out_b = func_b[dut_in_b];

   truth_table_sweeper u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a),
      .dut_in(dut_in_a), .dut_out(dut_out_a), .table_out(table_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch_cnt(mism_a),
      .first_fail(ff_a), .fail_valid(fv_a)
   );

   truth_table_sweeper #(.N_IN(4), .SETTLE(0)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b),
      .dut_in(dut_in_b), .dut_out(dut_out_b), .table_out(table_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch_cnt(mism_b),
      .first_fail(ff_b), .fail_valid(fv_b)
   );

   // selected-instance view
   logic        sel = 1'b0;
   logic [3:0]  v_in, v_ff;
   logic [15:0] v_tab;
   logic        v_busy, v_done, v_pass, v_fv;
   logic [4:0]  v_mism;
   always_comb begin
      v_in   = sel ? dut_in_b : dut_in_a;
      v_tab  = sel ? table_b  : table_a;
      v_busy = sel ? busy_b   : busy_a;
      v_done = sel ? done_b   : done_a;
      v_pass = sel ? pass_b   : pass_a;
      v_mism = sel ? mism_b   : mism_a;
      v_ff   = sel ? ff_b     : ff_a;
      v_fv   = sel ? fv_b     : fv_a;
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model helpers
   function automatic int popcnt(input logic [15:0] v);
      int c = 0;
      for (int i = 0; i < 16; i++) c += int'(v[i]);
      return c;
   endfunction

   function automatic int lowest(input logic [15:0] v);
      int r = 0;
      for (int i = 15; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   function automatic logic [15:0] xor4_table();
      logic [15:0] t;
      for (int i = 0; i < 16; i++) t[i] = ^(4'(i));
      return t;
   endfunction

   function automatic logic [15:0] andor_table();
      logic [15:0] t;
      logic [3:0] v;
      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         t[i] = (v[3] & v[2]) | (v[1] & v[0]);
      end
      return t;
   endfunction

   task automatic set_inputs(input logic [15:0] f, input logic [15:0] e, input logic s);
      if (sel) begin func_b = f; exp_b = e; start_b = s; end
      else     begin func_a = f; exp_a = e; start_a = s; end
   endtask

   task automatic set_start(input logic s);
      if (sel) start_b = s; else start_a = s;
   endtask

   task automatic set_exp(input logic [15:0] e);
      if (sel) exp_b = e; else exp_a = e;
   endtask

   // full sweep on the selected instance; noise pokes start and expected mid-sweep
   task automatic run_sweep(input string tag, input logic [15:0] f,
                            input logic [15:0] e, input bit noise);
      int settle = sel ? 0 : 1;
      int done_edge = 16 * (settle + 1) + 1;
      int got_edge = -1;
      int want_in;
      logic [15:0] diff = f ^ e;
      set_inputs(f, e, 1'b1);
      tick();                               // accepting edge (edge 0)
      set_start(1'b0);
      chk({tag, ".busy0"}, 32'(v_busy), 32'd1);
      chk({tag, ".done_clr"}, 32'(v_done), 32'd0);
      for (int k = 1; k <= 60; k++) begin
         if (noise) begin
            set_start((k == 5) || (k == 20));
            set_exp(16'($urandom));
         end
         tick();
         want_in = (k / (settle + 1) > 15) ? 15 : k / (settle + 1);
         if (v_in !== 4'(want_in)) chk({tag, ".dut_in"}, 32'(v_in), 32'(want_in));
         if (v_done) begin
            got_edge = k;
            break;
         end
      end
      set_start(1'b0);
      chk({tag, ".done_edge"}, 32'(got_edge), 32'(done_edge));
      chk({tag, ".table"}, 32'(v_tab), 32'(f));
      chk({tag, ".mism"}, 32'(v_mism), 32'(popcnt(diff)));
      chk({tag, ".fv"}, 32'(v_fv), 32'(diff != 0));
      if (diff != 0) chk({tag, ".first"}, 32'(v_ff), 32'(lowest(diff)));
      chk({tag, ".pass"}, 32'(v_pass), 32'(diff == 0));
      tick();
      chk({tag, ".busy_end"}, 32'(v_busy), 32'd0);
      chk({tag, ".in_hold"}, 32'(v_in), 32'd15);
      chk({tag, ".done_hold"}, 32'(v_done), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".in"},   32'(dut_in_a), 32'd0);
      chk({tag, ".tab"},  32'(table_a),  32'd0);
      chk({tag, ".busy"}, 32'(busy_a),   32'd0);
      chk({tag, ".done"}, 32'(done_a),   32'd0);
      chk({tag, ".pass"}, 32'(pass_a),   32'd0);
      chk({tag, ".mism"}, 32'(mism_a),   32'd0);
      chk({tag, ".ff"},   32'(ff_a),     32'd0);
      chk({tag, ".fv"},   32'(fv_a),     32'd0);
   endtask

   initial begin
      logic [15:0] rf, re;
      bit hit7;

      // reset state
      #2;
      check_all_zero("reset");
      #20;
      rst_n = 1'b1;
      tick();

      // directed sweeps on the SETTLE=1 build
      sel = 1'b0;
      run_sweep("xor_ok",   xor4_table(), 16'h6996, 1'b0);
      run_sweep("xor_bit0", xor4_table(), 16'h6997, 1'b0);
      run_sweep("xor_zero", xor4_table(), 16'h0000, 1'b0);
      run_sweep("noise",    xor4_table(), 16'h6996, 1'b1);

      // reset mid-sweep while dut_in == 7
      set_inputs(xor4_table(), 16'h6997, 1'b1);
      tick();
      set_start(1'b0);
      hit7 = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (dut_in_a == 4'd7) begin
            hit7 = 1'b1;
            break;
         end
         tick();
      end
      chk("rst_reach7", 32'(hit7), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrst");
      #1 rst_n = 1'b1;
      tick();
      chk("midrst_nodone", 32'(done_a), 32'd0);
      run_sweep("post_rst", xor4_table(), 16'h6996, 1'b0);

      // randomized sweeps on both builds
      for (int r = 0; r < 3; r++) begin
         rf = 16'($urandom);
         re = (r == 0) ? rf : rf ^ 16'($urandom);
         run_sweep($sformatf("randA%0d", r), rf, re, 1'b0);
      end

      // SETTLE=0 build
      sel = 1'b1;
      run_sweep("andor", andor_table(), 16'hF888, 1'b0);
      chk("andor_pass", 32'(pass_b), 32'd1);
      // restart while done=1
      set_start(1'b1);
      tick();
      set_start(1'b0);
      chk("restart.done", 32'(done_b), 32'd0);
      chk("restart.busy", 32'(busy_b), 32'd1);
      chk("restart.pass", 32'(pass_b), 32'd0);
      for (int k = 0; k < 40 && !done_b; k++) tick();
      chk("restart.fin", 32'(done_b), 32'd1);
      chk("restart.pass2", 32'(pass_b), 32'd1);
      for (int r = 0; r < 2; r++) begin
         rf = 16'($urandom);
         re = 16'($urandom);
         run_sweep($sformatf("randB%0d", r), rf, re, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
